// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {StFree, StDivZero, StDivOn, StDone} state_e;

  state_e r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_dvd, r_dvs, r_quot, r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_q_neg, r_r_neg, r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic             w_a_neg, w_b_neg, w_early, w_last, w_qbit, w_go;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quot_fix, w_rem_fix;
  logic [WIDTH:0]   w_partial, w_diff;

  assign w_go    = start_i & ~annul_i;
  assign w_a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign w_b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -opdata1_i : opdata1_i;
  assign w_b_mag = w_b_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
  assign w_partial  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_partial - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_quot_fix = r_q_neg ? -r_quot : r_quot;
  assign w_rem_fix  = r_r_neg ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFree;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StFree: begin
        if (w_go) begin
          if (opdata2_i == '0) begin
            w_state_nxt = StDivZero;
          end else if (w_early) begin
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StDivOn;
          end
        end
      end
      StDivZero: w_state_nxt = annul_i ? StFree : StDone;
      StDivOn: begin
        if (annul_i) begin
          w_state_nxt = StFree;
        end else if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (!w_go) begin
          w_state_nxt = StFree;
        end
      end
      default: w_state_nxt = StFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_result <= '0;
      unique case (r_state)
        StFree: begin
          if (w_go) begin
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_cnt   <= '0;
            r_quot  <= '0;
            // Early out leaves the whole dividend magnitude as the remainder.
            r_rem   <= w_early ? w_a_mag : '0;
          end
        end
        StDivZero: begin
          r_quot <= '0;
          r_rem  <= '0;
        end
        StDivOn: begin
          r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem  <= w_qbit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], w_qbit};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        StDone: begin
          if (w_go) begin
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quot_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against an arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i, opdata2_i;
  logic          start_i, annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;

  int n_total = 0;
  int n_bad   = 0;

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic longint to_int(input logic sgn, input logic [31:0] v);
    return sgn ? longint'($signed(v)) : longint'({32'h0, v});
  endfunction

  // Truncating division, remainder takes the dividend's sign; x/0 defined as 0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    sa = to_int(sgn, a);
    sb = to_int(sgn, b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (b == 32'h0) return 2;
    ma = to_int(sgn, a);
    mb = to_int(sgn, b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (Early && ma < mb) return 1;
    return W + 1;
  endfunction

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit pre_annul);
    int cyc;
    bit seen;
    logic [63:0] want;
    want = ref_div(sgn, a, b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = pre_annul;
    @(posedge clk);
    #1;
    check({tag, "_rdy_e0"}, 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    if (!pre_annul) begin
      signed_div_i = ~sgn;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = ready_o;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat(sgn, a, b) + (pre_annul ? 1 : 0)));
    check({tag, "_res"}, result_o, want);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {result_o[62:0], ready_o}, {want[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rdy_off"}, 64'(ready_o), 64'd0);
    check({tag, "_res_off"}, result_o, 64'd0);
  endtask

  initial begin
    int sel;
    logic sgn;
    logic [31:0] a, b;
    int cyc;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    check("reset_rdy", 64'(ready_o), 64'd0);
    check("reset_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("u100_7",   1'b0, 32'd100,      32'd7,        1'b0);
    run_op("s_m7_2",   1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op("s_7_m2",   1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b0);
    run_op("u_div0",   1'b0, 32'h00001234, 32'h0,        1'b0);
    run_op("s_div0",   1'b1, 32'h80000000, 32'h0,        1'b0);
    run_op("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("u_max_1",  1'b0, 32'hFFFFFFFF, 32'h1,        1'b0);
    run_op("u3_10",    1'b0, 32'd3,        32'd10,       1'b0);
    run_op("s_m3_10",  1'b1, 32'hFFFFFFFD, 32'd10,       1'b0);
    run_op("annul_fr", 1'b0, 32'd100,      32'd7,        1'b1);

    // Annul at iteration 10; a fresh operation must then run from scratch.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_rdy", 64'(ready_o), 64'd0);
    run_op("after_annul", 1'b0, 32'd9, 32'd3, 1'b0);

    // Asynchronous reset mid-iteration, then a clean restart.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_divon_rdy", 64'(ready_o), 64'd0);
    check("rst_divon_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 1'b0, 32'd1000, 32'd3, 1'b0);

    // Asynchronous reset while the result is being presented clears outputs at once.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd6;
    start_i      = 1'b1;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("pre_rst_res", result_o, ref_div(1'b0, 32'd50, 32'd6));
    #2;
    rst = 1'b1;
    #1;
    check("rst_done_rdy", 64'(ready_o), 64'd0);
    check("rst_done_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel < 4) b = $urandom_range(1, 15);
      if (sel == 4) a = $urandom_range(0, 20);
      if (sgn && $urandom_range(0, 1) == 1 && sel < 4) b = -b;
      run_op($sformatf("rnd%0d", i), sgn, a, b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
